// File: rtl/alu_nbit_pipe.sv
// WIDTH-bit ALU with a one-deep registered result stage, valid/ready flow control and an op counter.
// Build option: define ALU_SAT_EN to saturate ADD/SUB on carry/borrow instead of wrapping.
module alu_nbit_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               carry_out,
  output logic               zero_out,
  output logic               neg_out,
  output logic [COUNT_W-1:0] op_count
);

  localparam int unsigned ShiftW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpSlt = 3'b111
  } op_e;

  op_e                w_op;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [ShiftW-1:0]  w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_zero;
  logic               w_neg;
  logic               w_accept;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_alu_out;
  logic               r_carry;
  logic               r_zero;
  logic               r_neg;
  logic [COUNT_W-1:0] r_op_count;

  assign w_op    = op_e'(alu_sel);
  assign w_sum   = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow.
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = b[ShiftW-1:0];

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    unique case (w_op)
      OpAdd: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
`ifdef ALU_SAT_EN
        if (w_sum[WIDTH]) w_res = '1;
`else
`endif
      end
      OpSub: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
`ifdef ALU_SAT_EN
        if (w_diff[WIDTH]) w_res = '0;
`else
`endif
      end
      OpAnd: w_res = a & b;
      OpOr:  w_res = a | b;
      OpXor: w_res = a ^ b;
      OpShl: w_res = a << w_shamt;
      OpShr: w_res = a >> w_shamt;
      OpSlt: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  // Flags follow the final (possibly saturated) result.
  assign w_zero   = (w_res == '0);
  assign w_neg    = w_res[WIDTH-1];

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_alu_out   <= w_res;
        r_carry     <= w_carry;
        r_zero      <= w_zero;
        r_neg       <= w_neg;
        r_op_count  <= r_op_count + COUNT_W'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign carry_out = r_carry;
  assign zero_out  = r_zero;
  assign neg_out   = r_neg;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_nbit_pipe.sv
// Self-checking bench for alu_nbit_pipe: directed vector table, handshake sequences,
// randomized cycle-level scoreboard (WIDTH=8) and an exhaustive WIDTH=4 sweep.
module tb_alu_nbit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, alu_out8;
  logic [2:0]  sel8;
  logic        carry8, zero8, neg8;
  logic [15:0] cnt8;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, alu_out4;
  logic [2:0]  sel4;
  logic        carry4, zero4, neg4;
  logic [3:0]  cnt4;

  alu_nbit_pipe #(.WIDTH(8), .COUNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .alu_sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8), .alu_out(alu_out8),
    .carry_out(carry8), .zero_out(zero8), .neg_out(neg8), .op_count(cnt8)
  );

  alu_nbit_pipe #(.WIDTH(4), .COUNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .alu_sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4), .alu_out(alu_out4),
    .carry_out(carry4), .zero_out(zero4), .neg_out(neg4), .op_count(cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from plain integer arithmetic for a w-bit datapath.
  function automatic void ref_op(input int unsigned w, input int unsigned a, input int unsigned b,
                                 input int unsigned sel, output int unsigned res, output bit c);
    int unsigned mask, s, shm;
    mask = (1 << w) - 1;
    shm = 1;
    while (shm < w) shm = shm << 1;
    s = b & (shm - 1);
    c = 1'b0;
    case (sel)
      0: begin
        res = (a + b) & mask;
        c   = ((a + b) >> w) != 0;
`ifdef ALU_SAT_EN
        if (c) res = mask;
`endif
      end
      1: begin
        res = (a - b) & mask;
        c   = a < b;
`ifdef ALU_SAT_EN
        if (c) res = 0;
`endif
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a << s) & mask;
      6: res = a >> s;
      default: res = (a < b) ? 1 : 0;
    endcase
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[10];

  // Scoreboard state for the random phase.
  bit          m_valid;
  int unsigned m_res;
  bit          m_c;
  logic [15:0] m_cnt;

  initial begin
`ifdef ALU_SAT_EN
    vecs[0] = '{8'hF0, 8'h20, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0};
`else
    vecs[0] = '{8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h07, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b1};
`endif
    vecs[2] = '{8'h81, 8'h09, 3'd5, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 8'h07, 3'd6, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 8'hC8, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hF0, 8'h0F, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 3'd3, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'hAA, 8'hAA, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'h07, 8'h05, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0};

    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; sel8 = 0;
    in_valid4 = 0; out_ready4 = 1; a4 = 0; b4 = 0; sel4 = 0;

    // Reset for two cycles.
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_alu_out", alu_out8, 0);
    chk("rst_flags", {carry8, zero8, neg8}, 0);
    chk("rst_op_count", cnt8, 0);
    chk("rst_in_ready", in_ready8, 1);

    // Directed vector table, one op per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid8 = 1; a8 = vecs[i].a; b8 = vecs[i].b; sel8 = vecs[i].sel;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid8, 1);
      chk($sformatf("vec%0d_res", i), alu_out8, vecs[i].res);
      chk($sformatf("vec%0d_czn", i), {carry8, zero8, neg8}, {vecs[i].c, vecs[i].z, vecs[i].n});
      chk($sformatf("vec%0d_cnt", i), cnt8, 16'(i + 1));
    end
    in_valid8 = 0;
    tick();
    chk("drain_valid", out_valid8, 0);

    // Backpressure: ADD held while XOR waits, then XOR replaces it with no bubble.
    rst = 1;
    tick();
    rst = 0;
    out_ready8 = 0; in_valid8 = 1; a8 = 8'h10; b8 = 8'h22; sel8 = 3'd0;
    #1 chk("bp_in_ready_empty", in_ready8, 1);
    tick();
    chk("bp_first_valid", out_valid8, 1);
    chk("bp_first_res", alu_out8, 8'h32);
    a8 = 8'h0F; b8 = 8'hF0; sel8 = 3'd4;
    #1 chk("bp_in_ready_full", in_ready8, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_hold_res", {out_valid8, alu_out8, carry8, zero8, neg8}, {1'b1, 8'h32, 3'b000});
      chk("bp_hold_cnt", cnt8, 1);
    end
    out_ready8 = 1;
    #1 chk("bp_in_ready_release", in_ready8, 1);
    tick();
    chk("bp_xor", {out_valid8, alu_out8, carry8, zero8, neg8}, {1'b1, 8'hFF, 3'b001});
    chk("bp_cnt", cnt8, 2);
    in_valid8 = 0;
    tick();
    chk("bp_drain", out_valid8, 0);

    // Reset while a result is stalled.
    out_ready8 = 0; in_valid8 = 1; a8 = 8'h33; b8 = 8'h11; sel8 = 3'd2;
    tick();
    chk("rsthold_valid", out_valid8, 1);
    rst = 1;
    tick();
    rst = 0; in_valid8 = 0; out_ready8 = 1;
    chk("rsthold_after", {out_valid8, alu_out8, carry8, zero8, neg8}, 0);
    chk("rsthold_cnt", cnt8, 0);

    // Randomized flow against a cycle-level scoreboard.
    m_valid = 0; m_res = 0; m_c = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      bit r, acc, c;
      int unsigned res;
      r          = ($urandom_range(0, 49) == 0);
      rst        = r;
      in_valid8  = ($urandom_range(0, 3) != 0);
      out_ready8 = ($urandom_range(0, 2) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 3'($urandom);
      #1 chk("rnd_in_ready", in_ready8, !m_valid || out_ready8);
      acc = in_valid8 && (!m_valid || out_ready8);
      ref_op(8, a8, b8, sel8, res, c);
      tick();
      if (r) begin
        m_valid = 0; m_res = 0; m_c = 0; m_cnt = 0;
        chk("rnd_rst_flags", {carry8, zero8, neg8}, 0);
      end else if (acc) begin
        m_valid = 1; m_res = res; m_c = c; m_cnt = m_cnt + 1;
      end else if (out_ready8) begin
        m_valid = 0;
      end
      chk("rnd_valid", out_valid8, m_valid);
      chk("rnd_cnt", cnt8, m_cnt);
      if (m_valid)
        chk("rnd_result", {alu_out8, carry8, zero8, neg8},
            {m_res[7:0], m_c, m_res[7:0] == 0, m_res[7]});
    end
    rst = 0; in_valid8 = 0; out_ready8 = 1;

    // Exhaustive WIDTH=4 sweep; 4-bit counter must wrap.
    rst = 1;
    tick();
    rst = 0;
    in_valid4 = 1;
    for (int i = 0; i < 2048; i++) begin
      bit c;
      int unsigned res;
      logic [10:0] v;
      v = 11'(i);
      a4 = v[3:0]; b4 = v[7:4]; sel4 = v[10:8];
      ref_op(4, a4, b4, sel4, res, c);
      tick();
      chk($sformatf("sweep a=%0h b=%0h sel=%0d", a4, b4, sel4),
          {out_valid4, alu_out4, carry4, zero4, neg4, cnt4},
          {1'b1, res[3:0], c, res[3:0] == 0, res[3], 4'(i + 1)});
    end
    in_valid4 = 0;
    tick();
    chk("sweep_wrap_cnt", cnt4, 0);
    chk("sweep_drain", out_valid4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
